// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one requester stream at a time onto a FIFO write port,
// holding the grant until end-of-packet or a maximum beat count forces release.
module fifo_wr_arbiter #(
    parameter int unsigned P_NUM_REQ   = 4,
    parameter int unsigned P_WIDTH     = 8,
    parameter int unsigned P_MAX_BEATS = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [P_NUM_REQ*P_WIDTH-1:0]   req_data,
    input  logic [P_NUM_REQ-1:0]           req_vld,
    input  logic [P_NUM_REQ-1:0]           req_last,
    output logic [P_NUM_REQ-1:0]           req_rdy,
    output logic [P_WIDTH-1:0]             wr_data,
    output logic                           wr_vld,
    input  logic                           wr_rdy,
    output logic [$clog2(P_NUM_REQ)-1:0]   gnt_id,
    output logic                           busy
);

    localparam int unsigned IdW  = $clog2(P_NUM_REQ);
    localparam int unsigned CntW = $clog2(P_MAX_BEATS);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e          state_q, state_d;
    logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]  gnt_q, gnt_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic            found;
    logic [IdW-1:0]  sel;
    logic [IdW-1:0]  idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        cnt_d    = cnt_q;
        wr_vld   = 1'b0;
        wr_data  = '0;
        req_rdy  = '0;
        busy     = 1'b0;
        found    = 1'b0;
        sel      = rr_ptr_q;
        idx      = '0;

        // Search upward from rr_ptr; power-of-2 count makes the add wrap naturally.
        for (int k = 0; k < int'(P_NUM_REQ); k++) begin
            idx = rr_ptr_q + IdW'(k);
            if (!found && req_vld[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    gnt_d   = sel;
                    cnt_d   = '0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                busy           = 1'b1;
                wr_vld         = req_vld[gnt_q];
                wr_data        = req_data[gnt_q*P_WIDTH +: P_WIDTH];
                req_rdy[gnt_q] = wr_rdy;
                if (wr_vld && wr_rdy) begin
                    cnt_d = cnt_q + CntW'(1);
                    // Last beat and beat limit coinciding still yields a single release.
                    if (req_last[gnt_q] || (cnt_q == CntW'(P_MAX_BEATS - 1))) begin
                        state_d  = StIdle;
                        rr_ptr_d = gnt_q + IdW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign gnt_id = gnt_q;

endmodule
